// File: rtl/wb_regfile_pkg.sv
// Shared pipeline package for the writeback stage and register file.
// Provides the datapath/address widths, the matching typedefs and the
// index of the hardwired-zero register.
package pipe_pkg;

  localparam int DATA_W   = 8;
  localparam int ADDR_W   = 3;
  localparam int REG_ZERO = 0;

  typedef logic [DATA_W-1:0] data_t;
  typedef logic [ADDR_W-1:0] regaddr_t;

endpackage

// File: rtl/wb_regfile_if.sv
// Writeback / register-file bus.
// master: pipeline side; drives MEM/WB latch outputs, commit controls and the
//         decode read addresses; receives read data, writeback value,
//         forwarding info and the retired-write counter.
// slave : wb_regfile side (the opposite directions).
interface wb_regfile_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3,
  parameter int CNT_W  = 16
);

  logic [DATA_W-1:0] alu_in;
  logic [DATA_W-1:0] mem_in;
  logic              MemToRegmux;
  logic              RegWrite;
  logic [ADDR_W-1:0] regwradd;
  logic [ADDR_W-1:0] rd_addr_a;
  logic [ADDR_W-1:0] rd_addr_b;
  logic [DATA_W-1:0] rd_data_a;
  logic [DATA_W-1:0] rd_data_b;
  logic [DATA_W-1:0] wb_data;
  logic              fwd_valid;
  logic [ADDR_W-1:0] fwd_addr;
  logic [DATA_W-1:0] fwd_data;
  logic [CNT_W-1:0]  retired_cnt;

  modport master (
    output alu_in, mem_in, MemToRegmux, RegWrite, regwradd, rd_addr_a, rd_addr_b,
    input  rd_data_a, rd_data_b, wb_data, fwd_valid, fwd_addr, fwd_data, retired_cnt
  );

  modport slave (
    input  alu_in, mem_in, MemToRegmux, RegWrite, regwradd, rd_addr_a, rd_addr_b,
    output rd_data_a, rd_data_b, wb_data, fwd_valid, fwd_addr, fwd_data, retired_cnt
  );

endinterface

// File: rtl/wb_regfile_regfile_2r1w.sv
// regfile_2r1w: 2^ADDR_W x DATA_W register array, two combinational read
// ports, one write port. r0 is never written and always reads 0. A read of
// the address being written this cycle returns the write data (bypass).
// Ports:
//   i_clk, i_rst_n       : clock, async active-low reset (clears the array)
//   i_we, i_waddr,
//   i_wdata              : write enable / address / data
//   i_raddr_a/b          : read addresses
//   o_rdata_a/b          : read data
module regfile_2r1w #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr_a,
  input  logic [ADDR_W-1:0] i_raddr_b,
  output logic [DATA_W-1:0] o_rdata_a,
  output logic [DATA_W-1:0] o_rdata_b
);
  import pipe_pkg::*;

  localparam int NREGS = 1 << ADDR_W;

  logic [DATA_W-1:0] r_regs [NREGS];
  logic              w_wr;

  assign w_wr = i_we && (i_waddr != ADDR_W'(REG_ZERO));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_wr) begin
      r_regs[i_waddr] <= i_wdata;
    end
  end

  // Zero masking is applied last so r0 wins over the bypass.
  always_comb begin
    o_rdata_a = r_regs[i_raddr_a];
    if (w_wr && (i_raddr_a == i_waddr)) o_rdata_a = i_wdata;
    if (i_raddr_a == ADDR_W'(REG_ZERO)) o_rdata_a = '0;
  end

  always_comb begin
    o_rdata_b = r_regs[i_raddr_b];
    if (w_wr && (i_raddr_b == i_waddr)) o_rdata_b = i_wdata;
    if (i_raddr_b == ADDR_W'(REG_ZERO)) o_rdata_b = '0;
  end

endmodule

// File: rtl/wb_regfile.sv
// wb_regfile: writeback stage + architectural register file.
// Selects ALU or load data, commits it to the register file, registers the
// last committed write for EX forwarding and counts retired writes.
// Ports:
//   clk2  : pipeline clock (posedge)
//   rst_n : async active-low reset
//   bus   : wb_regfile_if slave modport (MEM/WB inputs, read ports,
//           wb_data, fwd_valid/fwd_addr/fwd_data, retired_cnt)
module wb_regfile #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3,
  parameter int CNT_W  = 16
) (
  input  logic         clk2,
  input  logic         rst_n,
  wb_regfile_if.slave  bus
);
  import pipe_pkg::*;

  logic [DATA_W-1:0] w_wb_data;
  logic              w_commit;
  logic              r_fwd_valid;
  logic [ADDR_W-1:0] r_fwd_addr;
  logic [DATA_W-1:0] r_fwd_data;
  logic [CNT_W-1:0]  r_retired_cnt;

  assign w_wb_data = bus.MemToRegmux ? bus.mem_in : bus.alu_in;
  assign w_commit  = bus.RegWrite && (bus.regwradd != ADDR_W'(REG_ZERO));

  regfile_2r1w #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_rf (
    .i_clk     (clk2),
    .i_rst_n   (rst_n),
    .i_we      (w_commit),
    .i_waddr   (bus.regwradd),
    .i_wdata   (w_wb_data),
    .i_raddr_a (bus.rd_addr_a),
    .i_raddr_b (bus.rd_addr_b),
    .o_rdata_a (bus.rd_data_a),
    .o_rdata_b (bus.rd_data_b)
  );

  // fwd_valid is a one-cycle pulse; addr/data hold until the next commit.
  always_ff @(posedge clk2 or negedge rst_n) begin
    if (!rst_n) begin
      r_fwd_valid   <= 1'b0;
      r_fwd_addr    <= '0;
      r_fwd_data    <= '0;
      r_retired_cnt <= '0;
    end else begin
      r_fwd_valid <= w_commit;
      if (w_commit) begin
        r_fwd_addr    <= bus.regwradd;
        r_fwd_data    <= w_wb_data;
        r_retired_cnt <= r_retired_cnt + CNT_W'(1);
      end
    end
  end

  assign bus.wb_data     = w_wb_data;
  assign bus.fwd_valid   = r_fwd_valid;
  assign bus.fwd_addr    = r_fwd_addr;
  assign bus.fwd_data    = r_fwd_data;
  assign bus.retired_cnt = r_retired_cnt;

endmodule

// File: tb/tb_wb_regfile.sv
module tb_wb_regfile;
  import pipe_pkg::*;

  logic     clk2 = 1'b0;
  logic     rst_n = 1'b0;
  data_t    alu_in = '0, mem_in = '0;
  logic     MemToRegmux = 1'b0, RegWrite = 1'b0;
  regaddr_t regwradd = '0, rd_addr_a = '0, rd_addr_b = '0;

  int checks = 0;
  int errors = 0;

  always #5 clk2 = ~clk2;

  wb_regfile_if #(.DATA_W(8), .ADDR_W(3), .CNT_W(16)) bus  ();
  wb_regfile_if #(.DATA_W(8), .ADDR_W(3), .CNT_W(4))  bus4 ();

  assign bus.alu_in       = alu_in;
  assign bus.mem_in       = mem_in;
  assign bus.MemToRegmux  = MemToRegmux;
  assign bus.RegWrite     = RegWrite;
  assign bus.regwradd     = regwradd;
  assign bus.rd_addr_a    = rd_addr_a;
  assign bus.rd_addr_b    = rd_addr_b;
  assign bus4.alu_in      = alu_in;
  assign bus4.mem_in      = mem_in;
  assign bus4.MemToRegmux = MemToRegmux;
  assign bus4.RegWrite    = RegWrite;
  assign bus4.regwradd    = regwradd;
  assign bus4.rd_addr_a   = rd_addr_a;
  assign bus4.rd_addr_b   = rd_addr_b;

  wb_regfile #(.DATA_W(8), .ADDR_W(3), .CNT_W(16)) u_dut (
    .clk2  (clk2),
    .rst_n (rst_n),
    .bus   (bus)
  );

  wb_regfile #(.DATA_W(8), .ADDR_W(3), .CNT_W(4)) u_dut4 (
    .clk2  (clk2),
    .rst_n (rst_n),
    .bus   (bus4)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: architectural state as plain arrays and integers.
  data_t       m_regs [8];
  bit          m_fwd_valid;
  regaddr_t    m_fwd_addr;
  data_t       m_fwd_data;
  int unsigned m_cnt;

  function automatic void model_clear();
    foreach (m_regs[i]) m_regs[i] = '0;
    m_fwd_valid = 1'b0;
    m_fwd_addr  = '0;
    m_fwd_data  = '0;
    m_cnt       = 0;
  endfunction

  initial model_clear();

  always @(posedge clk2 or negedge rst_n) begin
    if (!rst_n) begin
      model_clear();
    end else begin
      data_t v;
      bit    c;
      v = MemToRegmux ? mem_in : alu_in;
      c = RegWrite && (regwradd != 0);
      m_fwd_valid = c;
      if (c) begin
        m_regs[regwradd] = v;
        m_fwd_addr = regwradd;
        m_fwd_data = v;
        m_cnt++;
      end
    end
  end

  function automatic data_t model_read(input regaddr_t a);
    data_t v;
    v = MemToRegmux ? mem_in : alu_in;
    if (a == 0) return '0;
    if (RegWrite && regwradd != 0 && regwradd == a) return v;
    return m_regs[a];
  endfunction

  // Compare process: every negedge, all outputs against the model.
  always @(negedge clk2) begin
    chk("wb_data",   32'(bus.wb_data),     32'(MemToRegmux ? mem_in : alu_in));
    chk("rd_data_a", 32'(bus.rd_data_a),   32'(model_read(rd_addr_a)));
    chk("rd_data_b", 32'(bus.rd_data_b),   32'(model_read(rd_addr_b)));
    chk("fwd_valid", 32'(bus.fwd_valid),   32'(m_fwd_valid));
    chk("fwd_addr",  32'(bus.fwd_addr),    32'(m_fwd_addr));
    chk("fwd_data",  32'(bus.fwd_data),    32'(m_fwd_data));
    chk("cnt16",     32'(bus.retired_cnt), m_cnt & 32'hFFFF);
    chk("cnt4",      32'(bus4.retired_cnt), m_cnt & 32'hF);
  end

  task automatic cyc();
    @(posedge clk2);
    #1;
  endtask

  initial begin
    cyc();
    cyc();
    rst_n = 1'b1;
    cyc();

    // Reset state: all addresses read 0 on both ports.
    for (int i = 0; i < 8; i++) begin
      rd_addr_a = regaddr_t'(i);
      rd_addr_b = regaddr_t'(7 - i);
      #1;
      chk("rst_rd_a", 32'(bus.rd_data_a), 32'h0);
      chk("rst_rd_b", 32'(bus.rd_data_b), 32'h0);
    end
    chk("rst_fwd_valid", 32'(bus.fwd_valid), 32'h0);
    chk("rst_cnt", 32'(bus.retired_cnt), 32'h0);
    cyc();

    // ALU write to r3 with same-cycle bypass.
    RegWrite = 1'b1; regwradd = 3'd3; MemToRegmux = 1'b0;
    alu_in = 8'hA5; mem_in = 8'h5A; rd_addr_a = 3'd3;
    #1;
    chk("byp_rd_a", 32'(bus.rd_data_a), 32'hA5);
    chk("byp_wb",   32'(bus.wb_data),   32'hA5);
    cyc();
    RegWrite = 1'b0;
    #1;
    chk("r3_fwd_valid", 32'(bus.fwd_valid),   32'h1);
    chk("r3_fwd_addr",  32'(bus.fwd_addr),    32'h3);
    chk("r3_fwd_data",  32'(bus.fwd_data),    32'hA5);
    chk("r3_cnt",       32'(bus.retired_cnt), 32'h1);
    chk("r3_array",     32'(bus.rd_data_a),   32'hA5);
    cyc();

    // Load data to r5, then idle.
    RegWrite = 1'b1; regwradd = 3'd5; MemToRegmux = 1'b1;
    mem_in = 8'h3C; alu_in = 8'h00;
    cyc();
    RegWrite = 1'b0; rd_addr_b = 3'd5;
    #1;
    chk("r5_rd_b",      32'(bus.rd_data_b), 32'h3C);
    chk("r5_fwd_valid", 32'(bus.fwd_valid), 32'h1);
    cyc();
    chk("idle_fwd_valid", 32'(bus.fwd_valid),   32'h0);
    chk("idle_fwd_data",  32'(bus.fwd_data),    32'h3C);
    chk("idle_fwd_addr",  32'(bus.fwd_addr),    32'h5);
    chk("idle_cnt",       32'(bus.retired_cnt), 32'h2);

    // Write to r0 is dropped.
    RegWrite = 1'b1; regwradd = 3'd0; MemToRegmux = 1'b0;
    alu_in = 8'hFF; rd_addr_a = 3'd0;
    #1;
    chk("r0_rd_a", 32'(bus.rd_data_a), 32'h0);
    chk("r0_wb",   32'(bus.wb_data),   32'hFF);
    cyc();
    RegWrite = 1'b0;
    #1;
    chk("r0_fwd_valid", 32'(bus.fwd_valid),   32'h0);
    chk("r0_cnt",       32'(bus.retired_cnt), 32'h2);
    chk("r0_fwd_data",  32'(bus.fwd_data),    32'h3C);

    // Both ports on the same address with bypass.
    RegWrite = 1'b1; regwradd = 3'd3; alu_in = 8'h77;
    rd_addr_a = 3'd3; rd_addr_b = 3'd3;
    #1;
    chk("same_rd_a", 32'(bus.rd_data_a), 32'h77);
    chk("same_rd_b", 32'(bus.rd_data_b), 32'h77);
    cyc();
    RegWrite = 1'b0;

    // Counter wrap on the CNT_W=4 instance.
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    cyc();
    for (int i = 0; i < 16; i++) begin
      RegWrite = 1'b1; MemToRegmux = 1'b0;
      regwradd = regaddr_t'((i % 7) + 1);
      alu_in = data_t'(i);
      cyc();
    end
    RegWrite = 1'b0;
    #1;
    chk("wrap_cnt4",  32'(bus4.retired_cnt), 32'h0);
    chk("wrap_cnt16", 32'(bus.retired_cnt),  32'h10);

    // Fill r1..r7 then assert reset mid-cycle.
    for (int i = 1; i < 8; i++) begin
      RegWrite = 1'b1; regwradd = regaddr_t'(i);
      alu_in = data_t'(8'h10 + i);
      cyc();
    end
    RegWrite = 1'b0;
    rd_addr_a = 3'd7;
    cyc();
    chk("pre_rst_r7", 32'(bus.rd_data_a), 32'h17);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_fwd_valid", 32'(bus.fwd_valid),    32'h0);
    chk("mid_rst_fwd_addr",  32'(bus.fwd_addr),     32'h0);
    chk("mid_rst_fwd_data",  32'(bus.fwd_data),     32'h0);
    chk("mid_rst_cnt",       32'(bus.retired_cnt),  32'h0);
    chk("mid_rst_cnt4",      32'(bus4.retired_cnt), 32'h0);
    chk("mid_rst_r7",        32'(bus.rd_data_a),    32'h0);
    cyc();
    rst_n = 1'b1;
    cyc();
    for (int i = 1; i < 8; i++) begin
      rd_addr_a = regaddr_t'(i);
      rd_addr_b = regaddr_t'(i);
      #1;
      chk("post_rst_rd_a", 32'(bus.rd_data_a), 32'h0);
      chk("post_rst_rd_b", 32'(bus.rd_data_b), 32'h0);
    end
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
